// File: rtl/state_readout_unit.sv
// Readout end of the state-vector datapath: turns streamed Q1.15 amplitudes into probabilities,
// tracks the most probable basis state and the vector norm. READOUT_PROB_STREAM_EN adds a per-beat probability stream.
module state_readout_unit #(
    parameter int unsigned N_QUBITS = 3,
    parameter int unsigned NORM_TOL = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_amp,
    input  logic                  in_last,
    output logic                  busy,
    output logic                  done,
    output logic [N_QUBITS-1:0]   outcome,
    output logic [15:0]           max_prob,
    output logic [15:0]           norm_q15,
    output logic                  norm_ok,
    output logic                  err_len
`ifdef READOUT_PROB_STREAM_EN
    ,
    output logic                  prob_valid,
    input  logic                  prob_ready,
    output logic [16+N_QUBITS-1:0] prob_data
`endif
);

    localparam int unsigned ACC_W = 31 + N_QUBITS;
    localparam logic [N_QUBITS-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [N_QUBITS-1:0]  cnt_q, cnt_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [30:0]          s1_sq_q, s1_sq_d;
    logic [N_QUBITS-1:0]  s1_idx_q, s1_idx_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [15:0]          max_q, max_d;
    logic [N_QUBITS-1:0]  idx_q, idx_d;
    logic                 err_pend_q, err_pend_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [N_QUBITS-1:0]  outcome_q, outcome_d;
    logic [15:0]          max_prob_q, max_prob_d;
    logic [15:0]          norm_q, norm_d;
    logic                 norm_ok_q, norm_ok_d;
    logic                 err_len_q, err_len_d;
`ifdef READOUT_PROB_STREAM_EN
    logic                 prob_valid_q, prob_valid_d;
    logic [16+N_QUBITS-1:0] prob_data_q, prob_data_d;
`endif

    logic signed [15:0]   re, im;
    logic signed [31:0]   re_sq, im_sq;
    logic [31:0]          sq_sum;
    logic [30:0]          sq_sat;
    logic [15:0]          s2_p;
    logic [15+N_QUBITS:0] norm_full;
    logic [15:0]          norm_sat;
    logic                 advance, fire, stage2, pipe_empty;

    always_comb begin
        re     = in_amp[31:16];
        im     = in_amp[15:0];
        re_sq  = re * re;
        im_sq  = im * im;
        // Each square is at most 2^30; only (-32768,-32768) reaches 2^31, so clamp instead of wrapping.
        sq_sum = $unsigned(re_sq) + $unsigned(im_sq);
        sq_sat = sq_sum[31] ? '1 : sq_sum[30:0];
        s2_p   = s1_sq_q[30] ? 16'h7fff : {1'b0, s1_sq_q[29:15]};

        norm_full = acc_q[ACC_W-1:15];
        norm_sat  = (|norm_full[15+N_QUBITS:15]) ? 16'h7fff : norm_full[15:0];

`ifdef READOUT_PROB_STREAM_EN
        advance    = ~prob_valid_q | prob_ready;
        pipe_empty = ~s1_valid_q & advance;
`else
        advance    = 1'b1;
        pipe_empty = ~s1_valid_q;
`endif
        in_ready = (state_q == S_ACCUM) & advance;
        fire     = in_valid & in_ready;
        stage2   = s1_valid_q & advance;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s1_valid_d = s1_valid_q;
        s1_sq_d    = s1_sq_q;
        s1_idx_d   = s1_idx_q;
        acc_d      = acc_q;
        max_d      = max_q;
        idx_d      = idx_q;
        err_pend_d = err_pend_q;
        outcome_d  = outcome_q;
        max_prob_d = max_prob_q;
        norm_d     = norm_q;
        norm_ok_d  = norm_ok_q;
        err_len_d  = err_len_q;
`ifdef READOUT_PROB_STREAM_EN
        prob_valid_d = prob_valid_q;
        prob_data_d  = prob_data_q;
        if (advance) begin
            prob_valid_d = s1_valid_q;
            prob_data_d  = {s1_idx_q, s2_p};
        end
`endif

        // The whole pipe moves together so a stalled skid register also holds stage 1.
        if (advance) begin
            s1_valid_d = fire;
            s1_sq_d    = sq_sat;
            s1_idx_d   = cnt_q;
        end

        if (stage2) begin
            acc_d = acc_q + ACC_W'(s1_sq_q);
            if (s2_p > max_q) begin
                max_d = s2_p;
                idx_d = s1_idx_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ACCUM;
                    cnt_d      = '0;
                    acc_d      = '0;
                    max_d      = '0;
                    idx_d      = '0;
                    err_pend_d = 1'b0;
                    outcome_d  = '0;
                    max_prob_d = '0;
                    norm_d     = '0;
                    norm_ok_d  = 1'b0;
                    err_len_d  = 1'b0;
                end
            end
            S_ACCUM: begin
                if (fire) begin
                    cnt_d = cnt_q + 1'b1;
                    if (in_last || (cnt_q == LAST_IDX)) begin
                        state_d    = S_DRAIN;
                        err_pend_d = ~(in_last && (cnt_q == LAST_IDX));
                    end
                end
            end
            S_DRAIN: begin
                if (pipe_empty) begin
                    state_d    = S_DONE;
                    outcome_d  = idx_q;
                    max_prob_d = max_q;
                    norm_d     = norm_sat;
                    norm_ok_d  = (16'h7fff - norm_sat) <= 16'(NORM_TOL);
                    err_len_d  = err_pend_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_sq_q    <= '0;
            s1_idx_q   <= '0;
            acc_q      <= '0;
            max_q      <= '0;
            idx_q      <= '0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            outcome_q  <= '0;
            max_prob_q <= '0;
            norm_q     <= '0;
            norm_ok_q  <= 1'b0;
            err_len_q  <= 1'b0;
`ifdef READOUT_PROB_STREAM_EN
            prob_valid_q <= 1'b0;
            prob_data_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_sq_q    <= s1_sq_d;
            s1_idx_q   <= s1_idx_d;
            acc_q      <= acc_d;
            max_q      <= max_d;
            idx_q      <= idx_d;
            err_pend_q <= err_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            outcome_q  <= outcome_d;
            max_prob_q <= max_prob_d;
            norm_q     <= norm_d;
            norm_ok_q  <= norm_ok_d;
            err_len_q  <= err_len_d;
`ifdef READOUT_PROB_STREAM_EN
            prob_valid_q <= prob_valid_d;
            prob_data_q  <= prob_data_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign outcome  = outcome_q;
    assign max_prob = max_prob_q;
    assign norm_q15 = norm_q;
    assign norm_ok  = norm_ok_q;
    assign err_len  = err_len_q;
`ifdef READOUT_PROB_STREAM_EN
    assign prob_valid = prob_valid_q;
    assign prob_data  = prob_data_q;
`endif

endmodule
